// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU front end: opcode map, FSM states,
// and the captured flag bundle.
package alu_pkg;

    localparam int unsigned MAX_OPCODE = 9;

    localparam logic [3:0] OP_0 = 4'd0;
    localparam logic [3:0] OP_1 = 4'd1;
    localparam logic [3:0] OP_2 = 4'd2;
    localparam logic [3:0] OP_3 = 4'd3;
    localparam logic [3:0] OP_4 = 4'd4;
    localparam logic [3:0] OP_5 = 4'd5;
    localparam logic [3:0] OP_6 = 4'd6;
    localparam logic [3:0] OP_7 = 4'd7;
    localparam logic [3:0] OP_8 = 4'd8;
    localparam logic [3:0] OP_9 = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
        logic cout;
    } alu_flags_t;

endpackage

// File: rtl/alu_resp_reg.sv
// Capture-and-hold register for the ALU result, flags and error marker.
module alu_resp_reg
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] y_d,
    input  alu_flags_t       flags_d,
    input  logic             err_d,
    output logic [WIDTH-1:0] y_q,
    output alu_flags_t       flags_q,
    output logic             err_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q     <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else if (load) begin
            y_q     <= y_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Sequential front end for the combinational ALU: one request per handshake,
// registered ALU drive, one settle cycle, captured result via response channel.
module alu_op_issuer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MAX_OPCODE = alu_pkg::MAX_OPCODE,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_opcode,
    input  logic             in_cin,
    input  logic             in_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v,
    output logic             out_cout,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    import alu_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_opcode_q, alu_opcode_d;
    logic             alu_cin_q, alu_cin_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             resp_load;
    logic [WIDTH-1:0] resp_y_d, resp_y_q;
    alu_flags_t       resp_flags_d, resp_flags_q;
    logic             resp_err_d, resp_err_q;
    logic             legal;

    assign legal = (32'(in_opcode) <= MAX_OPCODE);

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        alu_cin_d    = alu_cin_q;
        carry_d      = carry_q;
        count_d      = count_q;
        resp_load    = 1'b0;
        resp_y_d     = '0;
        resp_flags_d = '0;
        resp_err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (legal) begin
                        alu_a_d      = in_a;
                        alu_b_d      = in_b;
                        alu_opcode_d = in_opcode;
                        alu_cin_d    = in_chain ? carry_q : in_cin;
                        state_d      = ST_EXEC;
                    end else begin
                        // Rejects bypass the ALU: zeroed result, error marker set.
                        resp_load  = 1'b1;
                        resp_err_d = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                resp_load    = 1'b1;
                resp_y_d     = alu_y;
                resp_flags_d = '{n: alu_n, z: alu_z, c: alu_c, v: alu_v, cout: alu_cout};
                carry_d      = alu_cout;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    if (!resp_err_q) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_cin_q    <= 1'b0;
            carry_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            alu_cin_q    <= alu_cin_d;
            carry_q      <= carry_d;
            count_q      <= count_d;
        end
    end

    alu_resp_reg #(
        .WIDTH(WIDTH)
    ) u_resp_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (resp_load),
        .y_d    (resp_y_d),
        .flags_d(resp_flags_d),
        .err_d  (resp_err_d),
        .y_q    (resp_y_q),
        .flags_q(resp_flags_q),
        .err_q  (resp_err_q)
    );

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_cin    = alu_cin_q;
    assign out_y      = resp_y_q;
    assign out_n      = resp_flags_q.n;
    assign out_z      = resp_flags_q.z;
    assign out_c      = resp_flags_q.c;
    assign out_v      = resp_flags_q.v;
    assign out_cout   = resp_flags_q.cout;
    assign out_err    = resp_err_q;
    assign op_count   = count_q;

endmodule
